// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_ctrl_pkg
//  Purpose  : Shared widths, register indices and FSM encoding for the
//             rv32i register file access controller.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_X0   = 5'd0;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd2;
    localparam logic [REG_AW-1:0] REG_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DBG_ACC = 2'd2,
        ST_DBG_ACK = 2'd3
    } rf_ctrl_state_e;

endpackage : regfile_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_ctrl_if
//  Purpose  : Debug master single-word req/ack access bus.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic              dbg_req;
    logic              dbg_we;
    logic [REG_AW-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_wdata;
    logic              dbg_ack;
    logic [XLEN-1:0]   dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );

endinterface : regfile_ctrl_if
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_init_seq
//  Purpose  : Post-reset sweep pointer (x1..x31) and sticky completion flag.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_init_seq
    import regfile_ctrl_pkg::*;
#(
    parameter bit INIT_EN = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_step,
    output logic [REG_AW-1:0]      o_ptr,
    output logic                   o_last,
    output logic                   o_done
);

    logic [REG_AW-1:0] r_ptr;
    logic              r_done;

    assign o_ptr  = r_ptr;
    assign o_last = (r_ptr == REG_LAST);
    assign o_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 5'd1;
            r_done <= 1'b0;
        end else begin
            // Without a sweep the file is declared ready on the first clock.
            if (!INIT_EN) begin
                r_done <= 1'b1;
            end else if (i_step) begin
                if (o_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 5'd1;
                end
            end
        end
    end

endmodule : regfile_init_seq
`default_nettype wire

// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_ctrl
//  Purpose  : Arbitrates the regfile write port and read port 2 between the
//             init sweep, the core and a single-word debug master.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter bit              INIT_EN    = 1'b1,
    parameter logic [XLEN-1:0] INIT_VALUE = 32'h0000_0000,
    parameter logic [XLEN-1:0] SP_INIT    = 32'h0000_1000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              core_we,
    input  wire logic [REG_AW-1:0] core_wa,
    input  wire logic [XLEN-1:0]   core_wd,
    input  wire logic [REG_AW-1:0] core_ra2,
    output logic [XLEN-1:0]        core_rd2,
    output logic                   core_stall,
    output logic                   init_done,
    regfile_ctrl_if.slave          dbg,
    output logic                   rf_write,
    output logic [REG_AW-1:0]      rf_wa,
    output logic [XLEN-1:0]        rf_wd,
    output logic [REG_AW-1:0]      rf_ra2,
    input  wire logic [XLEN-1:0]   rf_rd2
);

    rf_ctrl_state_e    r_state;
    logic              r_dbg_ack;
    logic [XLEN-1:0]   r_dbg_rdata;

    logic [REG_AW-1:0] w_ptr;
    logic              w_last;
    logic              w_init_step;
    logic              w_rf_write;

    assign w_init_step = (r_state == ST_INIT);

    regfile_init_seq #(
        .INIT_EN (INIT_EN)
    ) u_init_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_init_step),
        .o_ptr  (w_ptr),
        .o_last (w_last),
        .o_done (init_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_EN ? ST_INIT : ST_IDLE;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_dbg_ack <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (w_last) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (dbg.dbg_req) r_state <= ST_DBG_ACC;
                end
                ST_DBG_ACC: begin
                    r_state   <= ST_DBG_ACK;
                    r_dbg_ack <= 1'b1;
                    if (!dbg.dbg_we) r_dbg_rdata <= rf_rd2;
                end
                default: begin
                    // Unconditional return guarantees the core an unstalled gap.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rf_write = core_we && (core_wa != REG_X0);
        rf_wa      = core_wa;
        rf_wd      = core_wd;
        rf_ra2     = core_ra2;
        case (r_state)
            ST_INIT: begin
                w_rf_write = 1'b1;
                rf_wa      = w_ptr;
                rf_wd      = (w_ptr == REG_SP) ? SP_INIT : INIT_VALUE;
            end
            ST_DBG_ACC: begin
                w_rf_write = dbg.dbg_we && (dbg.dbg_addr != REG_X0);
                rf_wa      = dbg.dbg_addr;
                rf_ra2     = dbg.dbg_addr;
                rf_wd      = dbg.dbg_wdata;
            end
            default: ;
        endcase
    end

    // The reset state is INIT, so the sweep write must be held off while in reset.
    assign rf_write      = w_rf_write && rst_n;
    assign core_stall    = (r_state == ST_INIT) || (r_state == ST_DBG_ACC);
    assign core_rd2      = rf_rd2;
    assign dbg.dbg_ack   = r_dbg_ack;
    assign dbg.dbg_rdata = r_dbg_rdata;

endmodule : regfile_ctrl
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_ctrl
//  Purpose  : Self-checking bench for regfile_ctrl with a regfile array and a
//             register-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_wa;
    logic [31:0] core_wd;
    logic [4:0]  core_ra2;
    logic [31:0] core_rd2;
    logic        core_stall;
    logic        init_done;
    logic        rf_write;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd2;

    regfile_ctrl_if dbg_if ();

    regfile_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_we    (core_we),
        .core_wa    (core_wa),
        .core_wd    (core_wd),
        .core_ra2   (core_ra2),
        .core_rd2   (core_rd2),
        .core_stall (core_stall),
        .init_done  (init_done),
        .dbg        (dbg_if),
        .rf_write   (rf_write),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra2     (rf_ra2),
        .rf_rd2     (rf_rd2)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    always @(posedge clk) if (rf_write) rf_mem[rf_wa] <= rf_wd;
    assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'h0 : rf_mem[rf_ra2];

    logic [31:0] model [32];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 2) ? 32'h0000_1000 : 32'h0;
    endtask

    task automatic reset_and_init();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", rf_write, 1'b0);
        chk("rst_stall", core_stall, 1'b1);
        chk("rst_ack", dbg_if.dbg_ack, 1'b0);
        chk("rst_rdata", dbg_if.dbg_rdata, 32'h0);
        chk("rst_done", init_done, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("sweep_first_wr", rf_write, 1'b1);
        chk("sweep_first_wa", rf_wa, 5'd1);
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("init_cycles", n, 31);
        chk("idle_stall", core_stall, 1'b0);
        model_reset();
    endtask

    task automatic core_write(input logic [4:0] a, input logic [31:0] d);
        core_we = 1'b1; core_wa = a; core_wd = d;
        #1;
        chk("core_stall", core_stall, 1'b0);
        chk("core_wr_en", rf_write, a != 5'd0);
        if (a != 5'd0) begin
            chk("core_wa", rf_wa, a);
            chk("core_wd", rf_wd, d);
        end
        @(posedge clk); #1;
        core_we = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    // Caller is at #1 after an edge with the controller in IDLE.
    task automatic dbg_op(input bit we, input logic [4:0] a, input logic [31:0] d,
                          input bit cw, input logic [4:0] cwa, input logic [31:0] cwd);
        int n;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_we = we; dbg_if.dbg_addr = a; dbg_if.dbg_wdata = d;
        core_we = cw; core_wa = cwa; core_wd = cwd;
        #1;
        if (cw) chk("same_cyc_core_wr", rf_write, cwa != 5'd0);
        if (cw && cwa != 5'd0) model[cwa] = cwd;
        @(posedge clk); #1;
        if (cw && cwa != 5'd0) chk("core_wr_landed", rf_mem[cwa], cwd);
        // A stalled core may keep presenting a writeback; it must be ignored.
        core_we = 1'b1; core_wa = 5'($urandom_range(1, 31)); core_wd = $urandom;
        #1;
        chk("acc_stall", core_stall, 1'b1);
        chk("acc_wr_en", rf_write, we && (a != 5'd0));
        chk("acc_ack", dbg_if.dbg_ack, 1'b0);
        if (we) begin
            chk("acc_wa", rf_wa, a);
            chk("acc_wd", rf_wd, d);
        end else begin
            chk("acc_ra2", rf_ra2, a);
        end
        core_we = 1'b0;
        n = 1;
        while (!dbg_if.dbg_ack && n < 8) begin
            @(posedge clk); #1; n++;
        end
        chk("ack_latency", n, 2);
        chk("ack_stall", core_stall, 1'b0);
        if (!we) chk("dbg_rdata", dbg_if.dbg_rdata, model[a]);
        else if (a != 5'd0) model[a] = d;
        dbg_if.dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", dbg_if.dbg_ack, 1'b0);
        chk("post_ack_stall", core_stall, 1'b0);
    endtask

    task automatic dbg_burst(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
        logic [4:0] addrs [4];
        int k, gap, cyc;
        bit prev_ack;
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2; addrs[3] = a3;
        k = 0; gap = 0; cyc = 0; prev_ack = 1'b0;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_we = 1'b0; dbg_if.dbg_addr = addrs[0];
        while (k < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++; gap++;
            if (prev_ack) chk("burst_idle_stall", core_stall, 1'b0);
            prev_ack = dbg_if.dbg_ack;
            if (dbg_if.dbg_ack) begin
                chk("burst_gap", gap, (k == 0) ? 2 : 3);
                chk("burst_rdata", dbg_if.dbg_rdata, model[addrs[k]]);
                chk("burst_ack_stall", core_stall, 1'b0);
                gap = 0;
                k++;
                if (k == 4) dbg_if.dbg_req = 1'b0;
                else dbg_if.dbg_addr = addrs[k];
            end
        end
        chk("burst_count", k, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        int          op;
        rst_n = 1'b0;
        core_we = 1'b0; core_wa = '0; core_wd = '0; core_ra2 = '0;
        dbg_if.dbg_req = 1'b0; dbg_if.dbg_we = 1'b0; dbg_if.dbg_addr = '0; dbg_if.dbg_wdata = '0;

        reset_and_init();
        dbg_op(1'b0, 5'd2, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);

        core_write(5'd7, 32'hDEAD_BEEF);
        dbg_op(1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0);

        dbg_op(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        dbg_op(1'b1, 5'd9, 32'h22, 1'b1, 5'd9, 32'h11);
        dbg_op(1'b0, 5'd9, 32'h0, 1'b0, 5'd0, 32'h0);

        dbg_burst(5'd2, 5'd7, 5'd9, 5'd0);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd = $urandom;
            case (op)
                0: core_write(ra, rd);
                1: dbg_op(1'b1, ra, rd, 1'b0, 5'd0, 32'h0);
                2: dbg_op(1'b0, ra, 32'h0, 1'b0, 5'd0, 32'h0);
                default: dbg_op(1'b1, ra, rd, 1'b1, 5'($urandom_range(0, 31)), $urandom);
            endcase
            core_ra2 = 5'($urandom_range(0, 31));
            #1;
            chk("core_rd2", core_rd2, model[core_ra2]);
        end
        for (int r = 0; r < 32; r++) dbg_op(1'b0, 5'(r), 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset while a debug access is in flight.
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_we = 1'b1; dbg_if.dbg_addr = 5'd2; dbg_if.dbg_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        chk("pre_rst_acc_stall", core_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", dbg_if.dbg_ack, 1'b0);
        chk("midrst_write", rf_write, 1'b0);
        chk("midrst_done", init_done, 1'b0);
        dbg_if.dbg_req = 1'b0;
        reset_and_init();
        dbg_op(1'b0, 5'd2, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_regfile_ctrl
`default_nettype wire
